motor_pwm_driver: RTL and testbench
===================================

MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

Interface
REQ-001 SHALL have parameter PRESCALE, default 4, meaning Clk cycles per PWM tick (>=1).
REQ-002 SHALL have parameter DEAD_TICKS, default 16, meaning ticks with both motor outputs low on a direction reversal (>=1).
REQ-003 SHALL have port Clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port Reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port COMANDO_PWM  input  8  duty command from the PID controller, 0..249 nominal.
REQ-006 SHALL have port DIR_A  input  1  direction request bit A from the PID controller.
REQ-007 SHALL have port DIR_B  input  1  direction request bit B from the PID controller.
REQ-008 SHALL have port PWM_OUT  output  1  registered PWM to the H-bridge enable.
REQ-009 SHALL have port MOTOR_A  output  1  registered H-bridge input A.
REQ-010 SHALL have port MOTOR_B  output  1  registered H-bridge input B.
REQ-011 SHALL have port PERIOD_START  output  1  one-Clk pulse at each PWM period boundary.

Function
REQ-012 SHALL assert an internal tick for one Clk every PRESCALE cycles from a prescaler counter 0..PRESCALE-1.
REQ-013 SHALL advance an 8-bit period counter on each tick, 0..249, wrapping 249->0; the period is 250 ticks.
REQ-014 SHALL define the boundary as the tick on which the counter wraps to 0, and SHALL pulse PERIOD_START in that same Clk.
REQ-015 SHALL latch COMANDO_PWM into a duty shadow register only at the boundary, clamping values 250..255 to 249.
REQ-016 SHALL leave a COMANDO_PWM change mid-period without effect until the next boundary.
REQ-017 SHALL drive PWM_OUT = 1 when state is FWD or REV and counter < shadow, else 0, registered with one Clk latency.
REQ-018 SHALL decode requests {DIR_A,DIR_B}: 10 = FWD, 01 = REV, 11 or 00 = BRAKE.
REQ-019 SHALL sample the request and evaluate FSM transitions only at the boundary.
REQ-020 SHALL implement FSM states BRAKE, FWD, REV and DEAD.
REQ-021 SHALL make the following transitions at the boundary, with an unchanged request holding the current state:
- BRAKE->FWD/REV;
- FWD/REV->BRAKE;
- FWD->DEAD when REV requested;
- REV->DEAD when FWD requested.
REQ-022 SHALL, in DEAD, count DEAD_TICKS ticks, then re-evaluate the current request immediately, not waiting for a boundary: go to the requested state, and go to BRAKE if the request equals the pre-DEAD direction.
REQ-023 SHALL drive outputs per state: BRAKE A=1,B=1,PWM=0; FWD A=1,B=0; REV A=0,B=1; DEAD A=0,B=0,PWM=0.
REQ-024 SHALL never drive MOTOR_A and MOTOR_B to 10 and 01 in consecutive Clk cycles.
REQ-025 SHALL, if PRESCALE=1, give every Clk a tick, with behaviour otherwise identical.

Reset
REQ-026 SHALL, with Reset_n=0 at a rising edge, force state=BRAKE, MOTOR_A=1, MOTOR_B=1, PWM_OUT=0, PERIOD_START=0, and clear all counters and the duty shadow.
REQ-027 SHALL treat reset asserted mid-period or mid-DEAD identically, abandoning the DEAD count.
REQ-028 SHALL produce the first boundary 250 ticks after Reset_n deasserts.

Structure
REQ-029 SHALL place PWM_PERIOD=250, PWM_MAX=249, the FSM state encoding and the request encodings in shared package motor_pkg.
REQ-030 SHALL implement the prescaler/tick as sub-module pwm_tick_gen (Clk, Reset_n, tick output); all other logic stays in motor_pwm_driver.

Verification (bench: PRESCALE=1, DEAD_TICKS=4)
REQ-031 SHALL cover the duty check: DIR=10, COMANDO_PWM=100 -> from the second boundary on, MOTOR_A=1, MOTOR_B=0, PWM_OUT high 100 of every 250 Clk.
REQ-032 SHALL cover the duty update: COMANDO_PWM changed 100->50 at counter 30 -> current period high 100, next period high 50.
REQ-033 SHALL cover the reversal: FWD running, DIR 10->01 -> at the boundary A=0,B=0,PWM=0 for 4 Clk, then A=0,B=1, and never a direct 10->01 transition.
REQ-034 SHALL cover clamping: COMANDO_PWM=255 -> high 249 of 250 Clk; COMANDO_PWM=0 -> PWM_OUT constantly 0 while in FWD.
REQ-035 SHALL cover braking: FWD running, DIR=11 -> at the boundary A=1,B=1,PWM=0; DIR=00 gives the same result.
REQ-036 SHALL cover reset: Reset_n=0 during DEAD at count 2 -> next edge A=1,B=1,PWM=0; after release the first PERIOD_START occurs 250 Clk later.

Source files
------------

// File: rtl/motor_pkg.sv
// motor_pkg
//   Shared definitions for the H-bridge PWM driver: PWM period constants,
//   FSM state encoding, direction request encodings, and helpers that
//   decode a request and map a state to its bridge drive levels.
package motor_pkg;

    localparam int          PWM_PERIOD = 250;
    localparam logic [7:0]  PWM_MAX    = 8'(PWM_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_BRAKE = 2'd0,
        ST_FWD   = 2'd1,
        ST_REV   = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    // {DIR_A, DIR_B} request codes; both 00 and 11 mean brake
    localparam logic [1:0] REQ_FWD      = 2'b10;
    localparam logic [1:0] REQ_REV      = 2'b01;
    localparam logic [1:0] REQ_BRAKE_HI = 2'b11;
    localparam logic [1:0] REQ_BRAKE_LO = 2'b00;

    // Drive levels for the bridge; pwm_en gates the duty comparator
    typedef struct packed {
        logic a;
        logic b;
        logic pwm_en;
    } drive_t;

    function automatic state_t decode_req(input logic [1:0] req);
        state_t s;
        case (req)
            REQ_FWD: s = ST_FWD;
            REQ_REV: s = ST_REV;
            default: s = ST_BRAKE;
        endcase
        return s;
    endfunction

    function automatic drive_t state_drive(input state_t s);
        drive_t d;
        case (s)
            ST_FWD:  d = '{a: 1'b1, b: 1'b0, pwm_en: 1'b1};
            ST_REV:  d = '{a: 1'b0, b: 1'b1, pwm_en: 1'b1};
            ST_DEAD: d = '{a: 1'b0, b: 1'b0, pwm_en: 1'b0};
            default: d = '{a: 1'b1, b: 1'b1, pwm_en: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen
//   Prescaler producing a one-Clk tick every PRESCALE cycles.
//   Ports:
//     Clk     - system clock, rising edge
//     Reset_n - synchronous active-low reset
//     o_tick  - high for one Clk when the prescaler is at its last count
module pwm_tick_gen #(
    parameter int PRESCALE = 4
) (
    input  logic Clk,
    input  logic Reset_n,
    output logic o_tick
);

    // Keep at least one bit so PRESCALE=1 still elaborates; the counter
    // then stays at 0 and every cycle is a tick.
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == CNT_LAST);
    assign o_tick = w_tick;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver
//   PWM generator and direction FSM for an H-bridge. A 250-tick period
//   counter compares against a duty shadow latched at each period boundary;
//   direction changes are taken at the boundary, and reversals pass through
//   a DEAD state with both bridge inputs low.
//   Ports:
//     Clk          - system clock, rising edge
//     Reset_n      - synchronous active-low reset
//     COMANDO_PWM  - duty command, 0..249 (250..255 clamp to 249)
//     DIR_A, DIR_B - direction request (10 fwd, 01 rev, 00/11 brake)
//     PWM_OUT      - registered PWM to the bridge enable
//     MOTOR_A/B    - registered bridge inputs
//     PERIOD_START - one-Clk pulse on the tick where the counter wraps
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int PRESCALE   = 4,
    parameter int DEAD_TICKS = 16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] COMANDO_PWM,
    input  logic       DIR_A,
    input  logic       DIR_B,
    output logic       PWM_OUT,
    output logic       MOTOR_A,
    output logic       MOTOR_B,
    output logic       PERIOD_START
);

    // The dead counter runs up to DEAD_TICKS on the exit edge
    localparam int              DEAD_W    = $clog2(DEAD_TICKS + 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_TICKS - 1);

    logic              w_tick;
    logic              w_boundary;
    logic              w_dead_done;
    state_t            w_req_state;
    state_t            w_state_next;
    drive_t            w_drive_next;
    drive_t            w_drive_cur;

    logic [7:0]        r_cnt;
    logic [7:0]        r_shadow;
    state_t            r_state;
    logic [DEAD_W-1:0] r_dead;
    logic              r_pre_fwd;
    logic              r_motor_a;
    logic              r_motor_b;
    logic              r_pwm;

    pwm_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .o_tick  (w_tick)
    );

    assign w_boundary   = w_tick && (r_cnt == PWM_MAX);
    assign w_req_state  = decode_req({DIR_A, DIR_B});
    assign w_dead_done  = (r_state == ST_DEAD) && w_tick && (r_dead == DEAD_LAST);
    assign PERIOD_START = w_boundary;
    assign PWM_OUT      = r_pwm;
    assign MOTOR_A      = r_motor_a;
    assign MOTOR_B      = r_motor_b;

    // Period counter and duty shadow
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_cnt    <= '0;
            r_shadow <= '0;
        end else if (w_tick) begin
            if (w_boundary) begin
                r_cnt    <= '0;
                r_shadow <= (COMANDO_PWM > PWM_MAX) ? PWM_MAX : COMANDO_PWM;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // FSM state register plus the DEAD bookkeeping that rides with it
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state   <= ST_BRAKE;
            r_dead    <= '0;
            r_pre_fwd <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state != ST_DEAD) begin
                r_dead <= '0;
                // remember which direction we left so the exit can refuse
                // to fall straight back into it
                if (w_state_next == ST_DEAD) begin
                    r_pre_fwd <= (r_state == ST_FWD);
                end
            end else if (w_tick) begin
                r_dead <= r_dead + 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BRAKE: begin
                if (w_boundary) begin
                    w_state_next = w_req_state;
                end
            end
            ST_FWD, ST_REV: begin
                if (w_boundary) begin
                    if (w_req_state == ST_BRAKE) begin
                        w_state_next = ST_BRAKE;
                    end else if (w_req_state != r_state) begin
                        w_state_next = ST_DEAD;
                    end
                end
            end
            ST_DEAD: begin
                // Exit is not aligned to a boundary; the request is
                // re-read at the moment the dead time expires.
                if (w_dead_done) begin
                    if ((w_req_state == ST_FWD &&  r_pre_fwd) ||
                        (w_req_state == ST_REV && !r_pre_fwd)) begin
                        w_state_next = ST_BRAKE;
                    end else begin
                        w_state_next = w_req_state;
                    end
                end
            end
            default: w_state_next = ST_BRAKE;
        endcase
    end

    // Output decode: bridge levels follow the next state so they change on
    // the same edge as the state; PWM uses the current state and counter,
    // which gives the one-Clk registered latency.
    always_comb begin
        w_drive_next = state_drive(w_state_next);
        w_drive_cur  = state_drive(r_state);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_motor_a <= 1'b1;
            r_motor_b <= 1'b1;
            r_pwm     <= 1'b0;
        end else begin
            r_motor_a <= w_drive_next.a;
            r_motor_b <= w_drive_next.b;
            r_pwm     <= w_drive_cur.pwm_en && (r_cnt < r_shadow);
        end
    end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb_motor_pwm_driver
//   Directed bench for motor_pwm_driver with PRESCALE=1, DEAD_TICKS=4.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_motor_pwm_driver;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] COMANDO_PWM;
    logic       DIR_A;
    logic       DIR_B;
    logic       PWM_OUT;
    logic       MOTOR_A;
    logic       MOTOR_B;
    logic       PERIOD_START;

    int checks = 0;
    int errors = 0;

    motor_pwm_driver #(
        .PRESCALE   (1),
        .DEAD_TICKS (4)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .COMANDO_PWM  (COMANDO_PWM),
        .DIR_A        (DIR_A),
        .DIR_B        (DIR_B),
        .PWM_OUT      (PWM_OUT),
        .MOTOR_A      (MOTOR_A),
        .MOTOR_B      (MOTOR_B),
        .PERIOD_START (PERIOD_START)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n cycles, returning how many of them had PWM_OUT high
    task automatic run(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(posedge Clk);
            #1;
            if (PWM_OUT) hi++;
        end
    endtask

    // Cycles from reset release (that cycle counted as 1) until PERIOD_START
    task automatic wait_period_start(output int n);
        n = 1;
        while (!PERIOD_START && n < 300) begin
            @(posedge Clk);
            #1;
            n++;
        end
    endtask

    // The bridge must never go straight from 10 to 01 or back
    logic [1:0] prev_ab = 2'b11;
    always @(negedge Clk) begin
        if (Reset_n === 1'b1) begin
            checks++;
            assert (!((prev_ab == 2'b10 && {MOTOR_A, MOTOR_B} == 2'b01) ||
                      (prev_ab == 2'b01 && {MOTOR_A, MOTOR_B} == 2'b10))) else begin
                errors++;
                $error("FAIL shoot_through: observed %b after %b", {MOTOR_A, MOTOR_B}, prev_ab);
            end
        end
        prev_ab = {MOTOR_A, MOTOR_B};
    end

    initial begin
        int h, h2, n;
        Reset_n     = 1'b0;
        COMANDO_PWM = 8'd0;
        DIR_A       = 1'b1;
        DIR_B       = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_ab_pwm_ps", {MOTOR_A, MOTOR_B, PWM_OUT, PERIOD_START}, 4'b1100);

        // Release with a forward request at duty 100
        DIR_A = 1'b1; DIR_B = 1'b0; COMANDO_PWM = 8'd100;
        Reset_n = 1'b1;
        wait_period_start(n);
        check("first_boundary_cycles", n, 250);

        // Period 1: brake -> fwd at the boundary
        run(1, h);
        check("fwd_ab", {MOTOR_A, MOTOR_B}, 2'b10);
        run(249, h2);
        check("duty100_p1", h + h2, 100);
        check("ps_p1", PERIOD_START, 1);
        run(250, h);
        check("duty100_p2", h, 100);
        check("ps_p2", PERIOD_START, 1);

        // Mid-period command change takes effect next period
        run(31, h);
        COMANDO_PWM = 8'd50;
        run(219, h2);
        check("duty_hold_100", h + h2, 100);
        run(250, h);
        check("duty_new_50", h, 50);

        // Clamping and zero duty
        COMANDO_PWM = 8'd255;
        run(250, h);
        check("duty_clamp_249", h, 249);
        COMANDO_PWM = 8'd0;
        run(250, h);
        check("duty_zero", h, 0);
        check("fwd_ab_zero", {MOTOR_A, MOTOR_B}, 2'b10);

        // Reversal through DEAD
        COMANDO_PWM = 8'd100;
        run(250, h);
        check("duty100_pre_rev", h, 100);
        DIR_A = 1'b0; DIR_B = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run(1, h);
            check("dead_ab_pwm", {MOTOR_A, MOTOR_B, PWM_OUT}, 3'b000);
        end
        run(1, h);
        check("rev_ab_pwm", {MOTOR_A, MOTOR_B, PWM_OUT}, 3'b010);
        run(245, h);
        check("rev_partial_hi", h, 96);
        check("ps_rev", PERIOD_START, 1);
        run(250, h);
        check("rev_full_hi", h, 100);

        // Brake with 11
        DIR_A = 1'b1; DIR_B = 1'b1;
        run(1, h);
        check("brake11_ab_pwm", {MOTOR_A, MOTOR_B, PWM_OUT}, 3'b110);
        run(249, h);
        check("brake11_hi", h, 0);

        // Back to forward, then brake with 00
        DIR_A = 1'b1; DIR_B = 1'b0;
        run(250, h);
        check("fwd_again_hi", h, 100);
        DIR_A = 1'b0; DIR_B = 1'b0;
        run(1, h);
        check("brake00_ab_pwm", {MOTOR_A, MOTOR_B, PWM_OUT}, 3'b110);
        run(249, h);
        check("brake00_hi", h, 0);

        // Reset during DEAD at count 2
        DIR_A = 1'b1; DIR_B = 1'b0;
        run(250, h);
        check("fwd_pre_reset_hi", h, 100);
        DIR_A = 1'b0; DIR_B = 1'b1;
        run(3, h);
        check("dead_before_reset", {MOTOR_A, MOTOR_B}, 2'b00);
        Reset_n = 1'b0;
        run(1, h);
        check("reset_in_dead", {MOTOR_A, MOTOR_B, PWM_OUT, PERIOD_START}, 4'b1100);
        Reset_n = 1'b1;
        wait_period_start(n);
        check("boundary_after_reset", n, 250);
        run(1, h);
        check("rev_after_reset", {MOTOR_A, MOTOR_B}, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
